watch_ctrl: RTL and testbench

Mode controller and time-of-day counter for the six-digit seven-segment clock. It sequences the HH:MM:SS fields from a 1 Hz tick, handles the set-time mode through three button pulses, and drives per-digit blank masks. Its outputs feed the digit splitter, the segment decoders and the six-digit scan driver.

---
 rtl/watch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_watch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_ctrl.sv
// HH:MM:SS counter and clock/set mode controller for the six-digit display.
// Optional blink mask generation is enabled with `define WATCH_CTRL_BLINK_EN.
module watch_ctrl #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [5:0] o_blink
);

  typedef enum logic [1:0] {
    ST_CLOCK    = 2'd0,
    ST_SET_SEC  = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_HOUR = 2'd3
  } state_t;

  if (BLINK_DIV < 2) begin : g_bad_div
    $error("BLINK_DIV must be at least 2");
  end

  state_t     r_state, w_state_nx;
  logic [5:0] w_sec_nx, w_min_nx;
  logic [4:0] w_hour_nx;
  logic       w_mode_nx;
  logic [1:0] w_pos_nx;
  logic       w_restart;

  function automatic logic [5:0] f_inc60(input logic [5:0] v);
    f_inc60 = (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] f_inc24(input logic [4:0] v);
    f_inc24 = (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // Next-state, next-time and blink-restart decode
  always_comb begin
    w_state_nx = r_state;
    w_sec_nx   = o_sec;
    w_min_nx   = o_min;
    w_hour_nx  = o_hour;
    w_restart  = 1'b0;
    case (r_state)
      ST_CLOCK: begin
        if (i_tick) begin
          w_sec_nx = f_inc60(o_sec);
          if (o_sec == 6'd59) begin
            w_min_nx = f_inc60(o_min);
            if (o_min == 6'd59) w_hour_nx = f_inc24(o_hour);
            else                w_hour_nx = o_hour;
          end else begin
            w_min_nx = o_min;
          end
        end else begin
          w_sec_nx = o_sec;
        end
        if (i_btn_mode) begin
          w_state_nx = ST_SET_SEC;
          w_restart  = 1'b1;
        end else begin
          w_state_nx = ST_CLOCK;
        end
      end
      ST_SET_SEC: begin
        if (i_btn_mode) begin
          w_state_nx = ST_CLOCK;
        end else begin
          if (i_btn_inc) w_sec_nx = f_inc60(o_sec);
          else           w_sec_nx = o_sec;
          if (i_btn_pos) begin
            w_state_nx = ST_SET_MIN;
            w_restart  = 1'b1;
          end else begin
            w_state_nx = ST_SET_SEC;
          end
        end
      end
      ST_SET_MIN: begin
        if (i_btn_mode) begin
          w_state_nx = ST_CLOCK;
        end else begin
          if (i_btn_inc) w_min_nx = f_inc60(o_min);
          else           w_min_nx = o_min;
          if (i_btn_pos) begin
            w_state_nx = ST_SET_HOUR;
            w_restart  = 1'b1;
          end else begin
            w_state_nx = ST_SET_MIN;
          end
        end
      end
      ST_SET_HOUR: begin
        if (i_btn_mode) begin
          w_state_nx = ST_CLOCK;
        end else begin
          if (i_btn_inc) w_hour_nx = f_inc24(o_hour);
          else           w_hour_nx = o_hour;
          if (i_btn_pos) begin
            w_state_nx = ST_SET_SEC;
            w_restart  = 1'b1;
          end else begin
            w_state_nx = ST_SET_HOUR;
          end
        end
      end
      default: w_state_nx = ST_CLOCK;
    endcase
  end

  // Mode and field outputs follow the next state so they are registered with it
  always_comb begin
    w_mode_nx = (w_state_nx != ST_CLOCK);
    case (w_state_nx)
      ST_SET_SEC:  w_pos_nx = 2'd0;
      ST_SET_MIN:  w_pos_nx = 2'd1;
      ST_SET_HOUR: w_pos_nx = 2'd2;
      default:     w_pos_nx = 2'd0;
    endcase
  end

  // State, time and mode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLOCK;
      o_sec   <= 6'd0;
      o_min   <= 6'd0;
      o_hour  <= 5'd0;
      o_mode  <= 1'b0;
      o_pos   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      o_sec   <= w_sec_nx;
      o_min   <= w_min_nx;
      o_hour  <= w_hour_nx;
      o_mode  <= w_mode_nx;
      o_pos   <= w_pos_nx;
    end
  end

`ifdef WATCH_CTRL_BLINK_EN
  localparam int            CW     = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] r_bcnt, w_bcnt_nx;
  logic          r_phase, w_phase_nx;
  logic [5:0]    w_blink_nx;

  // Blink divider; restarting on field entry makes the new field visible first
  always_comb begin
    if (!w_mode_nx || w_restart) begin
      w_bcnt_nx  = '0;
      w_phase_nx = 1'b0;
    end else if (r_bcnt == C_LAST) begin
      w_bcnt_nx  = '0;
      w_phase_nx = ~r_phase;
    end else begin
      w_bcnt_nx  = r_bcnt + CW'(1);
      w_phase_nx = r_phase;
    end
    case (w_state_nx)
      ST_SET_SEC:  w_blink_nx = {4'b0000, {2{w_phase_nx}}};
      ST_SET_MIN:  w_blink_nx = {2'b00, {2{w_phase_nx}}, 2'b00};
      ST_SET_HOUR: w_blink_nx = {{2{w_phase_nx}}, 4'b0000};
      default:     w_blink_nx = 6'b000000;
    endcase
  end

  // Blink counter, phase and mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      o_blink <= 6'b000000;
    end else begin
      r_bcnt  <= w_bcnt_nx;
      r_phase <= w_phase_nx;
      o_blink <= w_blink_nx;
    end
  end
`else
  assign o_blink = 6'b000000;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl: time kept as seconds-of-day in the model.
module tb_watch_ctrl;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0, i_tick = 1'b0, i_btn_mode = 1'b0, i_btn_pos = 1'b0, i_btn_inc = 1'b0;
  logic [5:0] o_sec, o_min, o_blink;
  logic [4:0] o_hour;
  logic       o_mode;
  logic [1:0] o_pos;

  int n_cmp = 0;
  int n_bad = 0;
  int m_t = 0, m_set = 0, m_pos = 0, m_k = 0;

  watch_ctrl #(.BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_mode(i_btn_mode),
    .i_btn_pos(i_btn_pos), .i_btn_inc(i_btn_inc), .o_sec(o_sec), .o_min(o_min),
    .o_hour(o_hour), .o_mode(o_mode), .o_pos(o_pos), .o_blink(o_blink)
  );

  always #5 clk = ~clk;

  wire [25:0] w_dut = {o_hour, o_min, o_sec, o_mode, o_pos, o_blink};

  function automatic logic [5:0] blink_of(input int is_set, input int pos, input int k);
    logic [5:0] b;
    b = 6'b000000;
`ifdef WATCH_CTRL_BLINK_EN
    if (is_set != 0 && ((k / BD) % 2) == 1) b = 6'b000011 << (2 * pos);
`endif
    return b;
  endfunction

  function automatic logic [25:0] model_vec();
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 1'(m_set), 2'(m_pos),
            blink_of(m_set, m_pos, m_k)};
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit md, input bit ps, input bit ic);
    int h, m, s;
    if (r) begin
      m_t = 0; m_set = 0; m_pos = 0; m_k = 0;
    end else if (m_set == 0) begin
      if (tk) m_t = (m_t + 1) % 86400;
      if (md) begin m_set = 1; m_pos = 0; m_k = 0; end
    end else if (md) begin
      m_set = 0; m_pos = 0; m_k = 0;
    end else begin
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      if (ic) begin
        if (m_pos == 0) s = (s + 1) % 60;
        else if (m_pos == 1) m = (m + 1) % 60;
        else h = (h + 1) % 24;
      end
      m_t = h * 3600 + m * 60 + s;
      if (ps) begin m_pos = (m_pos + 1) % 3; m_k = 0; end
      else m_k = m_k + 1;
    end
  endtask

  task automatic cycle(input bit r, input bit tk, input bit md, input bit ps, input bit ic);
    rst = r; i_tick = tk; i_btn_mode = md; i_btn_pos = ps; i_btn_inc = ic;
    @(posedge clk);
    model_step(r, tk, md, ps, ic);
    #1;
    rst = 1'b0; i_tick = 1'b0; i_btn_mode = 1'b0; i_btn_pos = 1'b0; i_btn_inc = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (w_dut !== 26'd0) begin
      n_bad++; $display("FAIL reset dut=%h expected=%h", w_dut, 26'd0);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut !== model_vec()) begin
      n_bad++; $display("FAIL reset_model dut=%h expected=%h", w_dut, model_vec());
    end
  endtask

  task automatic test_count();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (w_dut !== model_vec()) begin
        n_bad++; $display("FAIL count_tick%0d dut=%h expected=%h", i, w_dut, model_vec());
      end
    end
    n_cmp++;
    if (w_dut !== {5'd0, 6'd1, 6'd1, 1'b0, 2'd0, 6'd0}) begin
      n_bad++; $display("FAIL count_61 dut=%h expected=%h", w_dut, {5'd0, 6'd1, 6'd1, 1'b0, 2'd0, 6'd0});
    end
  endtask

  task automatic test_rollover();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut !== {5'd23, 6'd59, 6'd58, 1'b0, 2'd0, 6'd0}) begin
      n_bad++; $display("FAIL preload dut=%h expected=%h", w_dut, {5'd23, 6'd59, 6'd58, 1'b0, 2'd0, 6'd0});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut !== {5'd23, 6'd59, 6'd59, 1'b0, 2'd0, 6'd0}) begin
      n_bad++; $display("FAIL tick_235959 dut=%h expected=%h", w_dut, {5'd23, 6'd59, 6'd59, 1'b0, 2'd0, 6'd0});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut !== 26'd0) begin
      n_bad++; $display("FAIL midnight dut=%h expected=%h", w_dut, 26'd0);
    end
  endtask

  task automatic test_set_wrap();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (o_pos !== 2'd0 || o_mode !== 1'b1) begin
      n_bad++; $display("FAIL pos_sec pos=%0d mode=%0d expected pos=0 mode=1", o_pos, o_mode);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_pos !== 2'd1) begin
      n_bad++; $display("FAIL pos_min pos=%0d expected=1", o_pos);
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_pos !== 2'd2) begin
      n_bad++; $display("FAIL pos_hour pos=%0d expected=2", o_pos);
    end
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut !== {5'd1, 6'd0, 6'd3, 1'b0, 2'd0, 6'd0}) begin
      n_bad++; $display("FAIL set_wrap dut=%h expected=%h", w_dut, {5'd1, 6'd0, 6'd3, 1'b0, 2'd0, 6'd0});
    end
  endtask

  task automatic test_freeze();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (w_dut[25:6] !== {5'd0, 6'd0, 6'd7, 1'b1, 2'd1}) begin
        n_bad++; $display("FAIL set_tick%0d dut=%h expected=%h", i, w_dut[25:6], {5'd0, 6'd0, 6'd7, 1'b1, 2'd1});
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (w_dut[25:6] !== {5'd0, 6'd0, 6'd8, 1'b1, 2'd0}) begin
      n_bad++; $display("FAIL tick_and_mode dut=%h expected=%h", w_dut[25:6], {5'd0, 6'd0, 6'd8, 1'b1, 2'd0});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (w_dut !== {5'd0, 6'd0, 6'd8, 1'b0, 2'd0, 6'd0}) begin
      n_bad++; $display("FAIL mode_inc dut=%h expected=%h", w_dut, {5'd0, 6'd0, 6'd8, 1'b0, 2'd0, 6'd0});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (w_dut[25:6] !== {5'd0, 6'd0, 6'd9, 1'b1, 2'd1}) begin
      n_bad++; $display("FAIL inc_pos dut=%h expected=%h", w_dut[25:6], {5'd0, 6'd0, 6'd9, 1'b1, 2'd1});
    end
  endtask

  task automatic test_blink();
    logic [5:0] exp_b;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_b = 6'b000000;
`ifdef WATCH_CTRL_BLINK_EN
      if (i >= 8) exp_b = 6'b000011;
`endif
      n_cmp++;
      if (o_blink !== exp_b) begin
        n_bad++; $display("FAIL blink_sec%0d dut=%b expected=%b", i, o_blink, exp_b);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_b = 6'b000000;
`ifdef WATCH_CTRL_BLINK_EN
      if (i >= 8) exp_b = 6'b001100;
`endif
      n_cmp++;
      if (o_blink !== exp_b) begin
        n_bad++; $display("FAIL blink_min%0d dut=%b expected=%b", i, o_blink, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (w_dut[25:6] !== {5'd5, 6'd7, 6'd9, 1'b1, 2'd2}) begin
      n_bad++; $display("FAIL set_050709 dut=%h expected=%h", w_dut[25:6], {5'd5, 6'd7, 6'd9, 1'b1, 2'd2});
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (w_dut !== 26'd0) begin
      n_bad++; $display("FAIL reset_mid dut=%h expected=%h", w_dut, 26'd0);
    end
  endtask

  task automatic test_random();
    bit r, tk, md, ps, ic;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      tk = ($urandom_range(0, 9) < 4);
      md = ($urandom_range(0, 29) == 0);
      ps = ($urandom_range(0, 19) == 0);
      ic = ($urandom_range(0, 9) < 4);
      cycle(r, tk, md, ps, ic);
      n_cmp++;
      if (w_dut !== model_vec()) begin
        n_bad++; $display("FAIL random%0d dut=%h expected=%h", i, w_dut, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_set_wrap();
    test_freeze();
    test_blink();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
